// File: rtl/seq_detector_param_if.sv
// ---------------------------------------------------------------------------
// seq_detector_param_if
//   Groups the stream, configuration and status signals of
//   seq_detector_param. Clock and reset stay outside as plain ports.
//
//   Parameters: N (maximum pattern length), CNT_W (match counter width).
//   master : drives stream/config/clear, observes status (stimulus side)
//   slave  : the detector itself
//
//   input_sequence / in_valid : serial bit and its sample qualifier
//   cfg_we / cfg_pattern / cfg_len / cfg_overlap : configuration write
//   count_clr                 : synchronous match counter clear
//   detected / match_count / cfg_err : status outputs
// ---------------------------------------------------------------------------
interface seq_detector_param_if #(
    parameter int N     = 5,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(N + 1);

    logic             input_sequence;
    logic             in_valid;
    logic             cfg_we;
    logic [N-1:0]     cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             count_clr;
    logic             detected;
    logic [CNT_W-1:0] match_count;
    logic             cfg_err;

    modport master (
        output input_sequence, in_valid, cfg_we, cfg_pattern, cfg_len,
               cfg_overlap, count_clr,
        input  detected, match_count, cfg_err
    );

    modport slave (
        input  input_sequence, in_valid, cfg_we, cfg_pattern, cfg_len,
               cfg_overlap, count_clr,
        output detected, match_count, cfg_err
    );
endinterface

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//   Serial pattern detector with a runtime-programmable pattern of 1..N bits,
//   overlapping or non-overlapping detection, a registered one-cycle
//   `detected` pulse and a saturating match counter. Out of reset the
//   pattern is N ones, overlapping.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : seq_detector_param_if.slave (stream, config, status)
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int N     = 5,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_detector_param_if.slave  bus
);
    localparam int LEN_W = $clog2(N + 1);

    logic [N-1:0]     hist;
    logic [LEN_W-1:0] fill;
    logic [N-1:0]     pat;
    logic [LEN_W-1:0] len;
    logic             ovl;
    logic             detected_r;
    logic [CNT_W-1:0] count_r;
    logic             cfg_err_r;

    logic             sample;
    logic             cfg_ok;
    logic [N-1:0]     hist_next;
    logic [LEN_W-1:0] fill_next;
    logic             match;

    // Ones in the low l bits: selects the part of the history being compared.
    function automatic logic [N-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            m[i] = (i < int'(l));
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        // A config write steals the edge: the bit is dropped, no match check.
        sample    = bus.in_valid && !bus.cfg_we;
        cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(N));
        hist_next = {hist[N-2:0], bus.input_sequence};
        fill_next = (fill == LEN_W'(N)) ? fill : fill + 1'b1;
        match     = sample && (fill_next >= len) &&
                    (((hist_next ^ pat) & len_mask(len)) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist       <= '0;
            fill       <= '0;
            pat        <= '1;
            len        <= LEN_W'(N);
            ovl        <= 1'b1;
            detected_r <= 1'b0;
            count_r    <= '0;
            cfg_err_r  <= 1'b0;
        end else if (bus.cfg_we) begin
            detected_r <= 1'b0;
            if (cfg_ok) begin
                pat       <= bus.cfg_pattern;
                len       <= bus.cfg_len;
                ovl       <= bus.cfg_overlap;
                hist      <= '0;
                fill      <= '0;
                count_r   <= '0;
                cfg_err_r <= 1'b0;
            end else begin
                cfg_err_r <= 1'b1;
            end
        end else begin
            cfg_err_r  <= 1'b0;
            detected_r <= match;
            if (sample) begin
                hist <= hist_next;
                // Non-overlapping mode forgets the matched bits by emptying
                // the fill level; the history itself is simply masked.
                fill <= (match && !ovl) ? '0 : fill_next;
            end
            if (bus.count_clr) begin
                count_r <= match ? CNT_W'(1) : '0;
            end else if (match) begin
                count_r <= sat_inc(count_r);
            end
        end
    end

    assign bus.detected    = detected_r;
    assign bus.match_count = count_r;
    assign bus.cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//   Directed bench for seq_detector_param: one N=5/CNT_W=8 instance (a) and
//   one N=5/CNT_W=2 instance (b) for counter saturation. Inputs change 1 ns
//   after the rising edge; outputs are read at the same point.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.N(5), .CNT_W(8)) a_if ();
    seq_detector_param_if #(.N(5), .CNT_W(2)) b_if ();

    seq_detector_param #(.N(5), .CNT_W(8)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    seq_detector_param #(.N(5), .CNT_W(2)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic b);
        a_if.input_sequence = b;
        a_if.in_valid       = 1'b1;
        tick();
        a_if.in_valid       = 1'b0;
    endtask

    task automatic send_b(input logic b, input logic clr);
        b_if.input_sequence = b;
        b_if.in_valid       = 1'b1;
        b_if.count_clr      = clr;
        tick();
        b_if.in_valid       = 1'b0;
        b_if.count_clr      = 1'b0;
    endtask

    task automatic cfg_a(input logic [4:0] p, input logic [2:0] l, input logic o);
        a_if.cfg_we      = 1'b1;
        a_if.cfg_pattern = p;
        a_if.cfg_len     = l;
        a_if.cfg_overlap = o;
        tick();
        a_if.cfg_we      = 1'b0;
    endtask

    initial begin
        logic [6:0] bits7;
        logic [6:0] exp7;

        a_if.input_sequence = 1'b0; a_if.in_valid = 1'b0; a_if.cfg_we = 1'b0;
        a_if.cfg_pattern = '0; a_if.cfg_len = '0; a_if.cfg_overlap = 1'b0;
        a_if.count_clr = 1'b0;
        b_if.input_sequence = 1'b0; b_if.in_valid = 1'b0; b_if.cfg_we = 1'b0;
        b_if.cfg_pattern = '0; b_if.cfg_len = '0; b_if.cfg_overlap = 1'b0;
        b_if.count_clr = 1'b0;

        // Reset state
        #2;
        chk("rst_detected", 32'(a_if.detected), 32'd0);
        chk("rst_count", 32'(a_if.match_count), 32'd0);
        chk("rst_cfg_err", 32'(a_if.cfg_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Default config: 7 ones, pulses after bits 5, 6, 7
        for (int i = 0; i < 7; i++) begin
            send_a(1'b1);
            chk($sformatf("ones_det_bit%0d", i + 1), 32'(a_if.detected), (i >= 4) ? 32'd1 : 32'd0);
        end
        chk("ones_count", 32'(a_if.match_count), 32'd3);
        tick();
        chk("ones_det_idle", 32'(a_if.detected), 32'd0);

        // Pattern 1101, overlapping: stream 1,1,0,1,1,0,1
        bits7 = 7'b1101101;
        cfg_a(5'b01101, 3'd4, 1'b1);
        chk("cfg_count_cleared", 32'(a_if.match_count), 32'd0);
        chk("cfg_no_err", 32'(a_if.cfg_err), 32'd0);
        exp7 = 7'b0001001;
        for (int i = 0; i < 7; i++) begin
            send_a(bits7[6 - i]);
            chk($sformatf("ovl_det_bit%0d", i + 1), 32'(a_if.detected), 32'(exp7[6 - i]));
        end
        chk("ovl_count", 32'(a_if.match_count), 32'd2);

        // Same stream, non-overlapping
        cfg_a(5'b01101, 3'd4, 1'b0);
        exp7 = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            send_a(bits7[6 - i]);
            chk($sformatf("novl_det_bit%0d", i + 1), 32'(a_if.detected), 32'(exp7[6 - i]));
        end
        chk("novl_count", 32'(a_if.match_count), 32'd1);

        // 1,1,0,1 with 3-cycle in_valid gaps
        cfg_a(5'b01101, 3'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_a(bits7[6 - i]);
            chk($sformatf("gap_det_bit%0d", i + 1), 32'(a_if.detected), (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    chk($sformatf("gap_det_idle%0d_%0d", i + 1, g), 32'(a_if.detected), 32'd0);
                end
            end
        end
        tick();
        chk("gap_det_after", 32'(a_if.detected), 32'd0);
        chk("gap_count", 32'(a_if.match_count), 32'd1);

        // Illegal length write mid-stream; the 0 offered with it is dropped
        send_a(1'b1);
        send_a(1'b1);
        a_if.input_sequence = 1'b0;
        a_if.in_valid       = 1'b1;
        cfg_a(5'b00000, 3'd0, 1'b1);
        a_if.in_valid       = 1'b0;
        chk("bad_cfg_err", 32'(a_if.cfg_err), 32'd1);
        chk("bad_cfg_det", 32'(a_if.detected), 32'd0);
        chk("bad_cfg_count_kept", 32'(a_if.match_count), 32'd1);
        send_a(1'b0);
        chk("bad_cfg_err_once", 32'(a_if.cfg_err), 32'd0);
        chk("bad_cfg_det_b3", 32'(a_if.detected), 32'd0);
        send_a(1'b1);
        chk("bad_cfg_old_detects", 32'(a_if.detected), 32'd1);
        chk("bad_cfg_count", 32'(a_if.match_count), 32'd2);

        // CNT_W=2 instance: 10 ones saturate the counter at 3
        for (int i = 0; i < 10; i++) begin
            send_b(1'b1, 1'b0);
            if (i == 5) chk("sat_count_bit6", 32'(b_if.match_count), 32'd2);
            if (i == 6) chk("sat_count_bit7", 32'(b_if.match_count), 32'd3);
        end
        chk("sat_count_bit10", 32'(b_if.match_count), 32'd3);
        send_b(1'b1, 1'b1);
        chk("clr_on_match_det", 32'(b_if.detected), 32'd1);
        chk("clr_on_match_count", 32'(b_if.match_count), 32'd1);
        send_b(1'b1, 1'b0);
        chk("after_clr_count", 32'(b_if.match_count), 32'd2);

        // Asynchronous reset after 3 of 5 ones (restores default config)
        rst_n = 1'b0;
        #1;
        chk("rst_pre_count", 32'(a_if.match_count), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send_a(1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_det", 32'(a_if.detected), 32'd0);
        chk("async_rst_count", 32'(a_if.match_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_a(1'b1);
            chk($sformatf("post_rst_det_bit%0d", i + 1), 32'(a_if.detected), 32'd0);
        end
        send_a(1'b1);
        chk("post_rst_det_bit5", 32'(a_if.detected), 32'd1);
        chk("post_rst_count", 32'(a_if.match_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector for the single-bit sequence-detection path. It compares a gated serial bit stream against a runtime-programmable pattern of 1..N bits. Overlapping or non-overlapping detection is selectable. It emits a one-cycle `detected` pulse and keeps a saturating match counter. Reset configuration is pattern all-ones of length N, so with defaults the block acts as a 5-consecutive-ones detector.

## Interface
Parameters:
- `N`, 5: maximum pattern length in bits (N ≥ 2).
- `CNT_W`, 8: width of `match_count`.
- `LEN_W`, $clog2(N+1): width of `cfg_len`; derived, not overridden.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `input_sequence`  in  1  serial data bit.
- `in_valid`  in  1  `input_sequence` is sampled only on edges where this is 1.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_pattern`  in  N  pattern. `cfg_pattern[len-1]` is the first bit expected and `cfg_pattern[0]` the last. Bits ≥ len are ignored.
- `cfg_len`  in  LEN_W  pattern length; legal range 1..N.
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `count_clr`  in  1  synchronous clear of `match_count`.
- `detected`  out  1  one-cycle match pulse, registered.
- `match_count`  out  CNT_W  number of matches, saturating.
- `cfg_err`  out  1  one-cycle pulse when a write is rejected.

## Operation
- State registers:
  - `hist[N-1:0]`: shift register of sampled bits; newest bit at `hist[0]`.
  - `fill`: number of valid history bits, 0..N, saturating at N.
  - Active config: `pat`, `len`, `ovl`.
- Reset values:
  - `hist`=0, `fill`=0.
  - `pat`=all ones, `len`=N, `ovl`=1.
  - `detected`=0, `match_count`=0, `cfg_err`=0.
- Sample edge (`in_valid`=1, `cfg_we`=0):
  - `hist` ← {hist[N-2:0], input_sequence}.
  - `fill` ← min(fill+1, N).
- Match condition, evaluated on the post-shift history: `fill'` ≥ `len` and `hist'[len-1:0]` == `pat[len-1:0]`.
- On a match:
  - `detected` ← 1 for exactly one cycle.
  - `match_count` increments unless it is already at all ones; it then holds.
  - If `ovl`=0, `fill` ← 0, so the next match needs `len` fresh bits. `hist` is not cleared; it is masked by `fill`.
  - If `ovl`=1, `fill` is kept, so a match can occur again on the next sample.
- Any edge without a match, including `in_valid`=0 edges: `detected` ← 0. `hist` and `fill` hold on `in_valid`=0 edges.
- Config write (`cfg_we`=1):
  - If 1 ≤ `cfg_len` ≤ N: load `pat`, `len`, `ovl`; set `hist`=0, `fill`=0, `match_count`=0, `detected`=0.
  - Otherwise (illegal length): keep the existing config and history, and pulse `cfg_err` for one cycle.
- `count_clr`: `match_count` ← 0 on that edge. A simultaneous match yields `match_count`=1; `detected` still pulses.
- Simultaneous events:
  - `cfg_we` has priority over `in_valid`. The bit is discarded even if the write is rejected, and no match is evaluated on that edge.
  - `cfg_we` together with `count_clr` behaves as a plain config write.

## Timing
- Detection latency is 1 cycle: `detected` is high during the cycle after the rising edge that sampled the final pattern bit.
- `match_count` updates on the same edge that raises `detected`.
- `cfg_err` is high for the one cycle after the rejecting edge.
- A new config applies to the first sample edge after the write edge.
- Reset mid-stream: all state returns to reset values immediately and asynchronously. The first post-release sample counts as bit 1 of a new stream.
- `in_valid` gaps stretch the stream; they do not break a partial match.

## Test plan
- Reset defaults, 7 consecutive ones with `in_valid`=1:
  - `detected` pulses after bits 5, 6 and 7.
  - `match_count`=3.
- Program `pat`=4'b1101, `len`=4, `ovl`=1, then stream 1,1,0,1,1,0,1:
  - `detected` after bits 4 and 7; `match_count`=2.
  - Repeat with `ovl`=0: `detected` only after bit 4; `match_count`=1.
- Stream 1,1,0,1 with `in_valid`=0 gaps of 3 cycles between bits:
  - Single `detected` pulse, one cycle after the 4th valid sample; no pulse during gaps.
- `cfg_len`=0 write mid-stream:
  - `cfg_err` pulses once.
  - Old config still detects.
  - The bit presented on the write cycle is discarded.
- `CNT_W`=2, defaults, 10 consecutive ones: `match_count` saturates at 3.
- Then assert `count_clr` on the edge of a match: `match_count`=1 and `detected`=1.
- Assert `rst_n`=0 after 3 of 5 ones, release, then send 4 ones:
  - No detection.
  - One more one → `detected` pulse.
